// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// master drives load/start/stop, slave returns count/running/done.
interface countdown_timer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  load;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  start;
  logic                  stop;
  logic [DATA_WIDTH-1:0] count;
  logic                  running;
  logic                  done;

  modport master (
    output load, load_value, start, stop,
    input  count, running, done
  );

  modport slave (
    input  load, load_value, start, stop,
    output count, running, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/pause and a one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload from the last load.
module countdown_timer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99
) (
  input logic              clk,
  input logic              resetn,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO  = '0;

  state_t                state;
  logic [DATA_WIDTH-1:0] count_q;
  logic                  running_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] sat;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] reload_q;
`endif

  always_comb begin
    sat = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count_q   <= ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= ZERO;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        state     <= IDLE;
        count_q   <= sat;
        running_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_q  <= sat;
`endif
      end else if (bus.stop) begin
        // stop outside RUN only suppresses start
        if (state == RUN) begin
          state     <= PAUSE;
          running_q <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE, PAUSE: begin
            if (bus.start && count_q != ZERO) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (count_q > ONE) begin
              count_q <= count_q - ONE;
            end else if (count_q == ONE) begin
              count_q <= ZERO;
              done_q  <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q == ZERO) begin
                state     <= EXPIRED;
                running_q <= 1'b0;
              end
`else
              state     <= EXPIRED;
              running_q <= 1'b0;
`endif
            end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != ZERO) begin
                count_q <= reload_q;
              end else begin
                state     <= EXPIRED;
                running_q <= 1'b0;
              end
`else
              state     <= EXPIRED;
              running_q <= 1'b0;
`endif
            end
          end
          EXPIRED: begin
            count_q <= ZERO;
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
// Expected count/running/done triples are hand-computed per step.
module tb_countdown_timer;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  countdown_timer_if #(.DATA_WIDTH(16)) bus ();

  countdown_timer #(
    .DATA_WIDTH(16),
    .MAX       (99)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [15:0] cnt,
    input logic        run,
    input logic        dn
  );
    checks++;
    assert ({bus.count, bus.running, bus.done} === {cnt, run, dn})
    else begin
      errors++;
      $error("FAIL %s: got count=%0d running=%b done=%b, expected count=%0d running=%b done=%b",
             tag, bus.count, bus.running, bus.done, cnt, run, dn);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    resetn         = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    #12;
    chk("reset_state", 16'd0, 1'b0, 1'b0);
    resetn = 1'b1;

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_at_zero", 16'd0, 1'b0, 1'b0);

    bus.load = 1'b1;
    bus.load_value = 16'd200;
    tick();
    chk("sat_200", 16'd99, 1'b0, 1'b0);
    bus.load_value = 16'd100;
    tick();
    chk("sat_100", 16'd99, 1'b0, 1'b0);
    bus.load_value = 16'd99;
    tick();
    bus.load = 1'b0;
    chk("load_max", 16'd99, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run_99", 16'd99, 1'b1, 1'b0);
    tick();
    chk("run_98", 16'd98, 1'b1, 1'b0);
    bus.load = 1'b1;
    bus.stop = 1'b1;
    bus.start = 1'b1;
    bus.load_value = 16'd3;
    tick();
    bus.load = 1'b0;
    bus.stop = 1'b0;
    bus.start = 1'b0;
    chk("load_wins", 16'd3, 1'b0, 1'b0);
    tick();
    chk("idle_hold", 16'd3, 1'b0, 1'b0);

    bus.load = 1'b1;
    bus.load_value = 16'd5;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rst_run5", 16'd5, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_run3", 16'd3, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst", 16'd0, 1'b0, 1'b0);
    tick();
    chk("rst_held", 16'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick();
    chk("post_rst", 16'd0, 1'b0, 1'b0);
    bus.load = 1'b1;
    bus.load_value = 16'd1;
    tick();
    bus.load = 1'b0;
    chk("load_1", 16'd1, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run_1", 16'd1, 1'b1, 1'b0);
    tick();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("one_done", 16'd0, 1'b1, 1'b1);
    tick();
    chk("one_reload", 16'd1, 1'b1, 1'b0);

    bus.load = 1'b1;
    bus.load_value = 16'd3;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ar_3a", 16'd3, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ar_2", 16'd2, 1'b1, 1'b0);
      tick();
      chk("ar_1", 16'd1, 1'b1, 1'b0);
      tick();
      chk("ar_0", 16'd0, 1'b1, 1'b1);
      tick();
      chk("ar_3", 16'd3, 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("ar_stop", 16'd3, 1'b0, 1'b0);
    tick();
    chk("ar_paused", 16'd3, 1'b0, 1'b0);
    bus.load = 1'b1;
    bus.load_value = 16'd0;
    tick();
    bus.load = 1'b0;
    chk("ar_load0", 16'd0, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ar_start0", 16'd0, 1'b0, 1'b0);
`else
    chk("one_done", 16'd0, 1'b0, 1'b1);
    tick();
    chk("one_exp", 16'd0, 1'b0, 1'b0);

    bus.load = 1'b1;
    bus.load_value = 16'd5;
    tick();
    bus.load = 1'b0;
    chk("l5", 16'd5, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r5", 16'd5, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk("r5_dec", 16'(i), 1'b1, 1'b0);
    end
    tick();
    chk("r5_done", 16'd0, 1'b0, 1'b1);
    tick();
    chk("r5_exp", 16'd0, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("exp_start", 16'd0, 1'b0, 1'b0);
    tick();
    chk("exp_hold", 16'd0, 1'b0, 1'b0);

    bus.load = 1'b1;
    bus.load_value = 16'd2;
    tick();
    bus.load = 1'b0;
    chk("l2", 16'd2, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r2", 16'd2, 1'b1, 1'b0);
    tick();
    chk("r2_1", 16'd1, 1'b1, 1'b0);
    tick();
    chk("r2_done", 16'd0, 1'b0, 1'b1);
    tick();
    chk("r2_exp", 16'd0, 1'b0, 1'b0);

    bus.load = 1'b1;
    bus.load_value = 16'd10;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r10", 16'd10, 1'b1, 1'b0);
    for (int i = 9; i >= 7; i--) begin
      tick();
      chk("r10_dec", 16'(i), 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("pause", 16'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause_hold", 16'd7, 1'b0, 1'b0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("resume", 16'd7, 1'b1, 1'b0);
    for (int i = 6; i >= 1; i--) begin
      tick();
      chk("resume_dec", 16'(i), 1'b1, 1'b0);
    end
    tick();
    chk("resume_done", 16'd0, 1'b0, 1'b1);
    tick();
    chk("resume_exp", 16'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
